mdu_core: RTL and testbench

MDU_CORE -- requirements
Module: mdu_core

---
 rtl/mdu_core.sv | 140 ++++++++++++++
 tb/tb_mdu_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_core.sv
// Multiply/divide unit: HI/LO register pair with fixed-latency MULT/DIV.
// Results are latched at issue and written to HI/LO when the busy count expires.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [63:0]   res_reg, res_next;
  logic          wr_reg, wr_next;
  logic          busy_reg;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;

  logic        is_mul, is_div, launch;
  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quot_mag, rem_mag, quot, rem;

  assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);

  assign prod_u = {32'b0, A} * {32'b0, B};
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  assign neg_a    = (MDUOp == OP_DIV) && A[31];
  assign neg_b    = (MDUOp == OP_DIV) && B[31];
  assign mag_a    = neg_a ? -A : A;
  assign mag_b    = neg_b ? -B : B;
  assign quot_mag = (B == 32'b0) ? 32'b0 : mag_a / mag_b;
  assign rem_mag  = (B == 32'b0) ? 32'b0 : mag_a % mag_b;
  assign quot     = (neg_a ^ neg_b) ? -quot_mag : quot_mag;
  assign rem      = neg_a ? -rem_mag : rem_mag;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;
    wr_next    = wr_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    launch     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (Start) begin
          if (is_mul || is_div) begin
            launch = 1'b1;
          end else if (MDUOp == OP_MTHI) begin
            hi_next = A;
          end else if (MDUOp == OP_MTLO) begin
            lo_next = A;
          end
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (cnt_reg == CW'(1)) begin
          if (wr_reg) begin
            hi_next = res_reg[63:32];
            lo_next = res_reg[31:0];
          end
          state_next = IDLE;
          cnt_next   = '0;
          wr_next    = 1'b0;
          // A new MULT/DIV may chain on the completion edge so Busy never drops.
          launch     = Start && (is_mul || is_div);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (launch) begin
      if (is_mul) begin
        res_next   = (MDUOp == OP_MULT) ? prod_s : prod_u;
        wr_next    = 1'b1;
        cnt_next   = CW'(MULT_CYCLES);
        state_next = MUL_RUN;
      end else begin
        res_next   = {rem, quot};
        wr_next    = (B != 32'b0);
        cnt_next   = CW'(DIV_CYCLES);
        state_next = DIV_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      res_reg   <= '0;
      wr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
      wr_reg    <= wr_next;
      busy_reg  <= (state_next != IDLE);
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign Busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_core.sv
// Directed bench for mdu_core: table of single operations plus hand-written
// sequences for busy-time issue, back-to-back chaining and mid-operation reset.
module tb_mdu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  MDUOp = 4'b1111;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUOp = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    step();
    Start = 1'b0;
    MDUOp = 4'b1111;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_hi, prev_lo;
    int cycles;

    vecs[0]  = '{4'b0000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{4'b0001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{4'b0010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{4'b0011, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{4'b0010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{4'b0011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[6]  = '{4'b0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[7]  = '{4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[8]  = '{4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9]  = '{4'b0010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[10] = '{4'b0100, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
    vecs[11] = '{4'b0101, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
    vecs[12] = '{4'b0110, 32'hDEADBEEF, 32'h00000001, 32'h12345678, 32'hCAFEBABE, 0};
    vecs[13] = '{4'b0010, 32'hFFFFFFF9, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 10};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", {31'b0, Busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    prev_hi = 32'h0;
    prev_lo = 32'h0;
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      cycles = 0;
      while (Busy && cycles < 200) begin
        if (cycles == vecs[i].cyc - 1) begin
          check($sformatf("v%0d_hold_hi", i), HI, prev_hi);
          check($sformatf("v%0d_hold_lo", i), LO, prev_lo);
        end
        step();
        cycles++;
      end
      check($sformatf("v%0d_busy_cycles", i), cycles, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      $display("vec %0d op=%b a=%08h b=%08h -> busy %0d HI=%08h LO=%08h",
               i, vecs[i].op, vecs[i].a, vecs[i].b, cycles, HI, LO);
      prev_hi = vecs[i].hi;
      prev_lo = vecs[i].lo;
    end

    // MTLO / MTHI issued while busy are ignored
    issue(4'b0000, 32'h2, 32'h3);
    step();
    issue(4'b0101, 32'h0000DEAD, 32'h0);
    issue(4'b0100, 32'h0000BEEF, 32'h0);
    cycles = 3;
    while (Busy && cycles < 200) begin
      step();
      cycles++;
    end
    check("busy_mt_cycles", cycles, 5);
    check("busy_mt_hi", HI, 32'h0);
    check("busy_mt_lo", LO, 32'h6);
    $display("busy-issue seq: busy %0d HI=%08h LO=%08h", cycles, HI, LO);

    // Back-to-back MULT then DIV accepted on the completion edge
    issue(4'b0000, 32'h3, 32'h4);
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("b2b_busy_e%0d", e), {31'b0, Busy}, 32'h1);
    end
    issue(4'b0010, 32'h64, 32'h7);
    check("b2b_e5_lo", LO, 32'hC);
    check("b2b_e5_hi", HI, 32'h0);
    check("b2b_e5_busy", {31'b0, Busy}, 32'h1);
    for (int e = 6; e <= 14; e++) begin
      step();
      check($sformatf("b2b_busy_e%0d", e), {31'b0, Busy}, 32'h1);
    end
    check("b2b_e14_lo", LO, 32'hC);
    step();
    check("b2b_e15_busy", {31'b0, Busy}, 32'h0);
    check("b2b_e15_hi", HI, 32'h2);
    check("b2b_e15_lo", LO, 32'hE);
    $display("back-to-back seq: HI=%08h LO=%08h Busy=%0b", HI, LO, Busy);

    // Reset in the middle of a DIV aborts it
    issue(4'b0011, 32'h64, 32'h5);
    repeat (3) step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    check("abort_busy", {31'b0, Busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) step();
    check("abort_later_hi", HI, 32'h0);
    check("abort_later_lo", LO, 32'h0);
    check("abort_later_busy", {31'b0, Busy}, 32'h0);
    $display("abort seq: HI=%08h LO=%08h Busy=%0b", HI, LO, Busy);

    // First edge after reset release accepts Start
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    MDUOp = 4'b0100;
    A     = 32'hA5A5A5A5;
    Start = 1'b1;
    step();
    Start = 1'b0;
    MDUOp = 4'b1111;
    check("post_reset_mthi", HI, 32'hA5A5A5A5);
    check("post_reset_busy", {31'b0, Busy}, 32'h0);
    $display("post-reset MTHI: HI=%08h Busy=%0b", HI, Busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
